// File: rtl/hwpe_stream_tcdm_writer_pkg.sv
// Shared types for the TCDM stream writer: control/flag bundles,
// FSM encoding and a word-alignment helper.
package hwpe_stream_package;

    localparam int unsigned WRITER_CNT_WIDTH = 16;

    typedef struct packed {
        logic                        req_start;
        logic [31:0]                 base_addr;
        logic [WRITER_CNT_WIDTH-1:0] line_length;
        logic [WRITER_CNT_WIDTH-1:0] nb_lines;
        logic [31:0]                 line_stride;
    } ctrl_tcdm_writer_t;

    typedef struct packed {
        logic                        ready_start;
        logic                        busy;
        logic                        done;
        logic [WRITER_CNT_WIDTH-1:0] beat_cnt;
    } flags_tcdm_writer_t;

    typedef enum logic [1:0] {
        WRITER_IDLE    = 2'd0,
        WRITER_WORKING = 2'd1,
        WRITER_DONE    = 2'd2
    } state_tcdm_writer_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/hwpe_stream_tcdm_writer_if.sv
// TCDM master bundle (one 32-bit lane per port) and the
// valid/ready data stream consumed by the writer.
interface hwpe_stream_intf_tcdm #(
    parameter int unsigned NB = 1
);
    logic [NB-1:0]       req;
    logic [NB-1:0]       gnt;
    logic [NB-1:0]       wen;
    logic [NB-1:0][31:0] add;
    logic [NB-1:0][31:0] data;
    logic [NB-1:0][3:0]  be;

    modport master (
        output req, add, wen, be, data,
        input  gnt
    );

    modport slave (
        input  req, add, wen, be, data,
        output gnt
    );
endinterface

interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_SIZE = 32
);
    logic                   valid;
    logic                   ready;
    logic [DATA_SIZE-1:0]   data;
    logic [DATA_SIZE/8-1:0] strb;

    modport source (
        output valid, data, strb,
        input  ready
    );

    modport sink (
        input  valid, data, strb,
        output ready
    );
endinterface

// File: rtl/hwpe_stream_tcdm_writer_addrgen.sv
// 2-D address generator: word/line counters plus line base and
// intra-line offset registers, so no multiplier is needed.
module hwpe_stream_tcdm_writer_addrgen
    import hwpe_stream_package::*;
#(
    parameter int unsigned NB_TCDM_PORTS = 1,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 start,
    input  logic                 advance,
    input  logic [31:0]          base,
    input  logic [CNT_WIDTH-1:0] line_length,
    input  logic [CNT_WIDTH-1:0] nb_lines,
    input  logic [31:0]          line_stride,
    output logic [31:0]          addr,
    output logic                 last_beat
);

    localparam logic [31:0] WORD_STEP = 32'(NB_TCDM_PORTS * 4);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] len_q;
    logic [CNT_WIDTH-1:0] lines_q;
    logic [CNT_WIDTH-1:0] word_idx;
    logic [CNT_WIDTH-1:0] line_idx;
    logic [31:0]          stride_q;
    logic [31:0]          line_addr;
    logic [31:0]          word_off;
    logic                 line_end;

    assign line_end = word_idx == (len_q - CNT_ONE);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            len_q     <= '0;
            lines_q   <= '0;
            word_idx  <= '0;
            line_idx  <= '0;
            stride_q  <= '0;
            line_addr <= '0;
            word_off  <= '0;
        end else if (start) begin
            len_q     <= line_length;
            lines_q   <= nb_lines;
            stride_q  <= line_stride;
            line_addr <= word_align(base);
            word_idx  <= '0;
            line_idx  <= '0;
            word_off  <= '0;
        end else if (advance) begin
            if (line_end) begin
                word_idx  <= '0;
                word_off  <= '0;
                line_idx  <= line_idx + CNT_ONE;
                line_addr <= line_addr + stride_q;
            end else begin
                word_idx <= word_idx + CNT_ONE;
                word_off <= word_off + WORD_STEP;
            end
        end
    end

    // Wraps modulo 2^32 by construction.
    assign addr      = line_addr + word_off;
    assign last_beat = line_end && (line_idx == (lines_q - CNT_ONE));

endmodule

// File: rtl/hwpe_stream_tcdm_writer.sv
// Stream-to-TCDM writer: splits each stream beat over the TCDM ports
// and accepts the beat once every port has been granted its word.
module hwpe_stream_tcdm_writer
    import hwpe_stream_package::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned NB_TCDM_PORTS = DATA_WIDTH / 32,
    parameter int unsigned CNT_WIDTH     = WRITER_CNT_WIDTH
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        clear_i,
    hwpe_stream_intf_tcdm.master        tcdm,
    hwpe_stream_intf_stream.sink        stream,
    input  ctrl_tcdm_writer_t           ctrl_i,
    output flags_tcdm_writer_t          flags_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_tcdm_writer_t state;
    state_tcdm_writer_t state_nxt;

    logic [NB_TCDM_PORTS-1:0] granted;
    logic [NB_TCDM_PORTS-1:0] granting;
    logic [NB_TCDM_PORTS-1:0] covered;
    logic [CNT_WIDTH-1:0]     beat_cnt;
    logic [31:0]              addr;
    logic                     last_beat;
    logic                     working;
    logic                     launch;
    logic                     empty_xfer;
    logic                     beat_done;

    assign working    = state == WRITER_WORKING;
    assign launch     = (state == WRITER_IDLE) && ctrl_i.req_start;
    assign empty_xfer = (ctrl_i.line_length == '0) || (ctrl_i.nb_lines == '0);

    // A port counts as done once granted, now or in an earlier cycle.
    assign granting  = tcdm.req & tcdm.gnt;
    assign covered   = granted | granting;
    assign beat_done = working && stream.valid && (&covered);

    assign stream.ready = beat_done;

    for (genvar i = 0; i < NB_TCDM_PORTS; i++) begin : g_port
        assign tcdm.req[i]  = working && stream.valid && !granted[i];
        assign tcdm.add[i]  = addr + 32'(4 * i);
        assign tcdm.wen[i]  = 1'b0;
        assign tcdm.be[i]   = stream.strb[4*i +: 4];
        assign tcdm.data[i] = stream.data[32*i +: 32];
    end

    hwpe_stream_tcdm_writer_addrgen #(
        .NB_TCDM_PORTS (NB_TCDM_PORTS),
        .CNT_WIDTH     (CNT_WIDTH)
    ) i_addrgen (
        .clk         (clk_i),
        .rst         (rst_i),
        .clear       (clear_i),
        .start       (launch),
        .advance     (beat_done),
        .base        (ctrl_i.base_addr),
        .line_length (CNT_WIDTH'(ctrl_i.line_length)),
        .nb_lines    (CNT_WIDTH'(ctrl_i.nb_lines)),
        .line_stride (ctrl_i.line_stride),
        .addr        (addr),
        .last_beat   (last_beat)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            WRITER_IDLE: begin
                if (ctrl_i.req_start)
                    state_nxt = empty_xfer ? WRITER_DONE : WRITER_WORKING;
            end
            WRITER_WORKING: begin
                if (beat_done && last_beat)
                    state_nxt = WRITER_DONE;
            end
            WRITER_DONE: state_nxt = WRITER_IDLE;
            default:     state_nxt = WRITER_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state    <= WRITER_IDLE;
            granted  <= '0;
            beat_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (launch)
                beat_cnt <= '0;
            else if (beat_done)
                beat_cnt <= beat_cnt + CNT_ONE;
            if (beat_done)
                granted <= '0;
            else if (working)
                granted <= covered;
        end
    end

    assign flags_o.ready_start = state == WRITER_IDLE;
    assign flags_o.busy        = working;
    assign flags_o.done        = state == WRITER_DONE;
    assign flags_o.beat_cnt    = WRITER_CNT_WIDTH'(beat_cnt);

endmodule

// File: tb/tb_hwpe_stream_tcdm_writer.sv
// Directed bench for the TCDM writer with a per-port write scoreboard.
module tb_hwpe_stream_tcdm_writer;
    import hwpe_stream_package::*;

    localparam int DW = 64;
    localparam int NB = 2;

    typedef struct packed {
        logic [31:0] add;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;
    ctrl_tcdm_writer_t  ctrl;
    flags_tcdm_writer_t flags;

    hwpe_stream_intf_tcdm   #(.NB(NB))        tcdm ();
    hwpe_stream_intf_stream #(.DATA_SIZE(DW)) stream ();

    hwpe_stream_tcdm_writer #(
        .DATA_WIDTH    (DW),
        .NB_TCDM_PORTS (NB),
        .CNT_WIDTH     (16)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (clear),
        .tcdm    (tcdm),
        .stream  (stream),
        .ctrl_i  (ctrl),
        .flags_o (flags)
    );

    always #5 clk = ~clk;

    wr_t q0[$];
    wr_t q1[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_ready, n_done, req0, req1, first_rdy, last_rdy;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clr_counts();
        n_ready = 0; n_done = 0; req0 = 0; req1 = 0;
        first_rdy = -1; last_rdy = -1;
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin : mon
        wr_t got;
        wr_t e;
        logic have;
        if (!rst) begin
            for (int i = 0; i < NB; i++) begin
                if (tcdm.req[i] && tcdm.gnt[i]) begin
                    got = wr_t'{tcdm.add[i], tcdm.data[i], tcdm.be[i]};
                    have = (i == 0) ? (q0.size() != 0) : (q1.size() != 0);
                    chk($sformatf("wr_expected_p%0d", i), 64'(have), 64'd1);
                    if (have) begin
                        if (i == 0) e = q0.pop_front();
                        else e = q1.pop_front();
                        chk($sformatf("add_p%0d", i), 64'(got.add), 64'(e.add));
                        chk($sformatf("data_p%0d", i), 64'(got.data), 64'(e.data));
                        chk($sformatf("be_p%0d", i), 64'(got.be), 64'(e.be));
                        chk($sformatf("wen_p%0d", i), 64'(tcdm.wen[i]), 64'd0);
                    end
                end
            end
            chk("req_gate", 64'(tcdm.req & ~{NB{stream.valid}}), 64'd0);
            if (tcdm.req[0]) req0++;
            if (tcdm.req[1]) req1++;
            if (stream.ready) begin
                n_ready++;
                if (first_rdy < 0) first_rdy = cyc;
                last_rdy = cyc;
            end
            if (flags.done) n_done++;
        end
    end

    task automatic start(input logic [31:0] base, input logic [15:0] len,
                         input logic [15:0] nl, input logic [31:0] stride);
        ctrl.base_addr   = base;
        ctrl.line_length = len;
        ctrl.nb_lines    = nl;
        ctrl.line_stride = stride;
        ctrl.req_start   = 1'b1;
        @(posedge clk); #1;
        ctrl.req_start = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] a, input int gap,
                             input int d1, input logic [7:0] s);
        logic [63:0] d;
        int c;
        repeat (gap) begin
            stream.valid = 1'b0;
            @(posedge clk); #1;
        end
        d = {$urandom, $urandom};
        stream.data  = d;
        stream.strb  = s;
        stream.valid = 1'b1;
        q0.push_back(wr_t'{a, d[31:0], s[3:0]});
        q1.push_back(wr_t'{a + 32'd4, d[63:32], s[7:4]});
        c = 0;
        while (1) begin
            tcdm.gnt[1] = (c >= d1);
            @(negedge clk);
            if (stream.ready) break;
            if (c >= 20) begin
                checks++; errors++;
                $error("FAIL beat_timeout: observed=no_ready expected=ready");
                break;
            end
            @(posedge clk); #1;
            c++;
        end
        @(posedge clk); #1;
        tcdm.gnt = '1;
    endtask

    task automatic xfer(input logic [31:0] base, input int len, input int nl,
                        input logic [31:0] stride, input int gap, input int d1,
                        input logic fixed_strb);
        logic [31:0] a;
        logic [7:0]  s;
        for (int l = 0; l < nl; l++) begin
            for (int w = 0; w < len; w++) begin
                a = base + 32'(l) * stride + 32'(w * 8);
                s = fixed_strb ? 8'h0F : 8'($urandom);
                send_beat(a, gap, d1, s);
            end
        end
        stream.valid = 1'b0;
        @(negedge clk);
        chk("done_pulse", 64'(flags.done), 64'd1);
        chk("done_busy", 64'(flags.busy), 64'd0);
        chk("done_req", 64'(tcdm.req), 64'd0);
        chk("beat_cnt", 64'(flags.beat_cnt), 64'(len * nl));
        @(posedge clk); #1;
        @(negedge clk);
        chk("done_one_cycle", 64'(flags.done), 64'd0);
        chk("ready_start_back", 64'(flags.ready_start), 64'd1);
        chk("beat_cnt_hold", 64'(flags.beat_cnt), 64'(len * nl));
        @(posedge clk); #1;
        chk("n_done", 64'(n_done), 64'd1);
        chk("q0_drained", 64'(q0.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        ctrl = '0;
        stream.valid = 1'b0;
        stream.data  = '0;
        stream.strb  = '0;
        tcdm.gnt     = '1;
        clr_counts();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready_start", 64'(flags.ready_start), 64'd1);
        chk("rst_busy", 64'(flags.busy), 64'd0);
        chk("rst_done", 64'(flags.done), 64'd0);
        chk("rst_beat_cnt", 64'(flags.beat_cnt), 64'd0);
        chk("rst_req", 64'(tcdm.req), 64'd0);
        chk("rst_ready", 64'(stream.ready), 64'd0);
        @(posedge clk); #1;

        // 1: single line, full grant, back-to-back beats
        clr_counts();
        start(32'h100, 16'd4, 16'd1, 32'h0);
        xfer(32'h100, 4, 1, 32'h0, 0, 0, 1'b0);
        chk("t1_ready_cnt", 64'(n_ready), 64'd4);
        chk("t1_throughput", 64'(last_rdy - first_rdy), 64'd3);

        // 2: three lines with stride
        clr_counts();
        start(32'h200, 16'd2, 16'd3, 32'h40);
        xfer(32'h200, 2, 3, 32'h40, 0, 0, 1'b0);
        chk("t2_ready_cnt", 64'(n_ready), 64'd6);

        // 3: port1 grant delayed three cycles
        clr_counts();
        start(32'h300, 16'd1, 16'd1, 32'h0);
        xfer(32'h300, 1, 1, 32'h0, 0, 3, 1'b0);
        chk("t3_req0_cycles", 64'(req0), 64'd1);
        chk("t3_req1_cycles", 64'(req1), 64'd4);
        chk("t3_ready_cnt", 64'(n_ready), 64'd1);

        // 4: valid toggling, strb 0x0F
        clr_counts();
        start(32'h400, 16'd4, 16'd1, 32'h0);
        xfer(32'h400, 4, 1, 32'h0, 1, 0, 1'b1);
        chk("t4_req0_cycles", 64'(req0), 64'd4);
        chk("t4_req1_cycles", 64'(req1), 64'd4);

        // 5: clear during third beat of eight
        clr_counts();
        start(32'h500, 16'd8, 16'd1, 32'h0);
        send_beat(32'h500, 0, 0, 8'hFF);
        send_beat(32'h508, 0, 0, 8'hFF);
        d = {$urandom, $urandom};
        stream.data  = d;
        stream.strb  = 8'hFF;
        stream.valid = 1'b1;
        tcdm.gnt[1]  = 1'b0;
        q0.push_back(wr_t'{32'h510, d[31:0], 4'hF});
        @(negedge clk);
        chk("t5_partial_ready", 64'(stream.ready), 64'd0);
        chk("t5_partial_req", 64'(tcdm.req), 64'd3);
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        chk("t5_clear_req", 64'(tcdm.req), 64'd0);
        chk("t5_clear_idle", 64'(flags.ready_start), 64'd1);
        chk("t5_clear_busy", 64'(flags.busy), 64'd0);
        chk("t5_clear_cnt", 64'(flags.beat_cnt), 64'd0);
        @(posedge clk); #1;
        stream.valid = 1'b0;
        tcdm.gnt = '1;
        repeat (2) @(posedge clk);
        #1;
        chk("t5_no_done", 64'(n_done), 64'd0);
        chk("t5_q0_empty", 64'(q0.size()), 64'd0);
        chk("t5_q1_empty", 64'(q1.size()), 64'd0);
        clr_counts();
        start(32'h600, 16'd2, 16'd2, 32'h20);
        xfer(32'h600, 2, 2, 32'h20, 0, 0, 1'b0);

        // 6: empty transfer
        clr_counts();
        start(32'h700, 16'd4, 16'd0, 32'h10);
        @(negedge clk);
        chk("t6_done", 64'(flags.done), 64'd1);
        chk("t6_not_ready_start", 64'(flags.ready_start), 64'd0);
        chk("t6_req", 64'(tcdm.req), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_done_off", 64'(flags.done), 64'd0);
        chk("t6_ready_start", 64'(flags.ready_start), 64'd1);
        chk("t6_beat_cnt", 64'(flags.beat_cnt), 64'd0);
        @(posedge clk); #1;
        chk("t6_no_req", 64'(req0 + req1), 64'd0);
        chk("t6_n_done", 64'(n_done), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
